// File: rtl/reg8_access_arbiter.sv
// Two-requester arbiter in front of a shared WIDTH-bit register.
// Round-robin tie break; commit on last grant cycle; one-cycle done.
module reg8_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [WIDTH-1:0] din_a,
  output logic             gnt_a,
  output logic             done_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [WIDTH-1:0] din_b,
  output logic             gnt_b,
  output logic             done_b,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic [7:0]       wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(HOLD - 1);

  state_t           state;
  state_t           state_nx;
  logic             owner;
  logic             owner_nx;
  logic             last;
  logic             last_nx;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nx;
  logic [WIDTH-1:0] q_nx;
  logic [7:0]       wr_nx;

  logic             req_o;
  logic             we_o;
  logic [WIDTH-1:0] din_o;

  logic             gnt_a_nx;
  logic             gnt_b_nx;
  logic             done_a_nx;
  logic             done_b_nx;
  logic             busy_nx;

  // owner/last: 0 = A, 1 = B
  always_comb begin
    req_o = owner ? req_b : req_a;
    we_o  = owner ? we_b  : we_a;
    din_o = owner ? din_b : din_a;
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    q_nx     = q;
    wr_nx    = wr_count;
    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_nx = GRANT;
          cnt_nx   = 4'd0;
          if (req_a && req_b) begin
            owner_nx = ~last;
          end else begin
            owner_nx = req_b;
          end
          last_nx = owner_nx;
        end
      end
      GRANT: begin
        if (!req_o) begin
          state_nx = IDLE;
        end else if (cnt == LAST_CNT) begin
          state_nx = DONE;
          if (we_o) begin
            q_nx = din_o;
            if (wr_count != 8'hFF) begin
              wr_nx = wr_count + 8'd1;
            end
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next state so they leave a flop directly
  always_comb begin
    gnt_a_nx  = (state_nx == GRANT) && !owner_nx;
    gnt_b_nx  = (state_nx == GRANT) &&  owner_nx;
    done_a_nx = (state_nx == DONE)  && !owner_nx;
    done_b_nx = (state_nx == DONE)  &&  owner_nx;
    busy_nx   = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!CLR) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= 4'd0;
      q        <= '0;
      wr_count <= 8'd0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      cnt      <= cnt_nx;
      q        <= q_nx;
      wr_count <= wr_nx;
      gnt_a    <= gnt_a_nx;
      gnt_b    <= gnt_b_nx;
      done_a   <= done_a_nx;
      done_b   <= done_b_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_reg8_access_arbiter.sv
// Directed bench for reg8_access_arbiter.
// HOLD=1 and HOLD=3 instances share one stimulus bus.
module tb_reg8_access_arbiter;

  logic       clk = 1'b0;
  logic       CLR;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] din_a, din_b;

  logic       ga1, gb1, da1, db1, busy1;
  logic [7:0] q1, wr1;
  logic       ga3, gb3, da3, db3, busy3;
  logic [7:0] q3, wr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg8_access_arbiter #(.WIDTH(8), .HOLD(1)) u1 (
    .clk(clk), .CLR(CLR),
    .req_a(req_a), .we_a(we_a), .din_a(din_a),
    .gnt_a(ga1), .done_a(da1),
    .req_b(req_b), .we_b(we_b), .din_b(din_b),
    .gnt_b(gb1), .done_b(db1),
    .q(q1), .busy(busy1), .wr_count(wr1)
  );

  reg8_access_arbiter #(.WIDTH(8), .HOLD(3)) u3 (
    .clk(clk), .CLR(CLR),
    .req_a(req_a), .we_a(we_a), .din_a(din_a),
    .gnt_a(ga3), .done_a(da3),
    .req_b(req_b), .we_b(we_b), .din_b(din_b),
    .gnt_b(gb3), .done_b(db3),
    .q(q3), .busy(busy3), .wr_count(wr3)
  );

  typedef struct {
    logic       clr;
    logic       ra;
    logic       wa;
    logic [7:0] da;
    logic       rb;
    logic       wb;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       dna;
    logic       dnb;
    logic       bsy;
    logic [7:0] q;
    logic [7:0] wr;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic ra, input logic wa,
                       input logic [7:0] da, input logic rb,
                       input logic wb, input logic [7:0] db);
    CLR = c; req_a = ra; we_a = wa; din_a = da;
    req_b = rb; we_b = wb; din_b = db;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    chk("excl1", {31'd0, ga1 & gb1}, 32'd0);
    chk("excl3", {31'd0, ga3 & gb3}, 32'd0);
  endtask

  int         wr_exp;
  logic [7:0] q_exp;
  logic       own_b;

  initial begin
    // clr ra wa da rb wb db | ga gb dna dnb bsy q wr
    tv[0]  = '{0,1,1,8'hAB,1,1,8'hCD, 0,0,0,0,0,8'h00,8'd0};
    tv[1]  = '{0,0,1,8'h12,1,0,8'h34, 0,0,0,0,0,8'h00,8'd0};
    tv[2]  = '{1,1,1,8'h56,0,0,8'h00, 1,0,0,0,1,8'h00,8'd0};
    tv[3]  = '{1,1,1,8'h56,0,0,8'h00, 0,0,1,0,1,8'h56,8'd1};
    tv[4]  = '{1,0,0,8'h00,0,0,8'h00, 0,0,0,0,0,8'h56,8'd1};
    tv[5]  = '{0,1,1,8'h99,1,1,8'h99, 0,0,0,0,0,8'h00,8'd0};
    tv[6]  = '{1,1,1,8'h56,1,1,8'hF0, 1,0,0,0,1,8'h00,8'd0};
    tv[7]  = '{1,1,1,8'h56,1,1,8'hF0, 0,0,1,0,1,8'h56,8'd1};
    tv[8]  = '{1,0,0,8'h00,1,1,8'hF0, 0,0,0,0,0,8'h56,8'd1};
    tv[9]  = '{1,0,0,8'h00,1,1,8'hF0, 0,1,0,0,1,8'h56,8'd1};
    tv[10] = '{1,0,0,8'h00,1,1,8'hF0, 0,0,0,1,1,8'hF0,8'd2};
    tv[11] = '{1,0,0,8'h00,0,0,8'h00, 0,0,0,0,0,8'hF0,8'd2};

    drive(0, 0, 0, 8'h00, 0, 0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].clr, tv[i].ra, tv[i].wa, tv[i].da,
            tv[i].rb, tv[i].wb, tv[i].db);
      step();
      chk($sformatf("v%0d.gnt_a", i), {31'd0, ga1}, {31'd0, tv[i].ga});
      chk($sformatf("v%0d.gnt_b", i), {31'd0, gb1}, {31'd0, tv[i].gb});
      chk($sformatf("v%0d.done_a", i), {31'd0, da1}, {31'd0, tv[i].dna});
      chk($sformatf("v%0d.done_b", i), {31'd0, db1}, {31'd0, tv[i].dnb});
      chk($sformatf("v%0d.busy", i), {31'd0, busy1}, {31'd0, tv[i].bsy});
      chk($sformatf("v%0d.q", i), {24'd0, q1}, {24'd0, tv[i].q});
      chk($sformatf("v%0d.wr", i), {24'd0, wr1}, {24'd0, tv[i].wr});
    end

    // Round robin, both held: A writes 8'h11, B reads
    wr_exp = 2;
    q_exp  = 8'hF0;
    drive(1, 1, 1, 8'h11, 1, 0, 8'hEE);
    for (int k = 0; k < 6; k++) begin
      own_b = k[0];
      step();
      chk($sformatf("rr%0d.gnt_a", k), {31'd0, ga1}, {31'd0, !own_b});
      chk($sformatf("rr%0d.gnt_b", k), {31'd0, gb1}, {31'd0, own_b});
      step();
      if (!own_b) begin
        q_exp = 8'h11;
        wr_exp++;
      end
      chk($sformatf("rr%0d.done_a", k), {31'd0, da1}, {31'd0, !own_b});
      chk($sformatf("rr%0d.done_b", k), {31'd0, db1}, {31'd0, own_b});
      chk($sformatf("rr%0d.q", k), {24'd0, q1}, {24'd0, q_exp});
      chk($sformatf("rr%0d.wr", k), {24'd0, wr1}, wr_exp);
      step();
      chk($sformatf("rr%0d.busy", k), {31'd0, busy1}, 32'd0);
    end

    // Saturation of the write counter
    for (int k = 0; k < 255; k++) begin
      drive(1, 1, 1, k[7:0], 0, 0, 8'h00);
      step();
      step();
      step();
    end
    chk("sat.wr", {24'd0, wr1}, 32'd255);
    chk("sat.q", {24'd0, q1}, 32'hFE);

    // HOLD=3 abort: req_a dropped in second grant cycle
    drive(0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    drive(1, 1, 1, 8'hAA, 0, 0, 8'h00);
    step();
    chk("ab.gnt1", {31'd0, ga3}, 32'd1);
    step();
    chk("ab.gnt2", {31'd0, ga3}, 32'd1);
    drive(1, 0, 1, 8'hAA, 0, 0, 8'h00);
    step();
    chk("ab.gnt", {31'd0, ga3}, 32'd0);
    chk("ab.busy", {31'd0, busy3}, 32'd0);
    chk("ab.done", {31'd0, da3}, 32'd0);
    chk("ab.q", {24'd0, q3}, 32'h00);
    step();
    chk("ab.busy2", {31'd0, busy3}, 32'd0);
    chk("ab.done2", {31'd0, da3}, 32'd0);
    chk("ab.wr", {24'd0, wr3}, 32'd0);

    // HOLD=3 reset in final grant cycle, then a tie must go to A
    drive(1, 1, 1, 8'h77, 0, 0, 8'h00);
    step();
    step();
    step();
    chk("rg.gnt3", {31'd0, ga3}, 32'd1);
    drive(0, 1, 1, 8'h77, 0, 0, 8'h00);
    step();
    chk("rg.q", {24'd0, q3}, 32'h00);
    chk("rg.gnt", {31'd0, ga3}, 32'd0);
    chk("rg.done", {31'd0, da3}, 32'd0);
    chk("rg.wr", {24'd0, wr3}, 32'd0);
    chk("rg.busy", {31'd0, busy3}, 32'd0);
    drive(1, 1, 1, 8'h77, 1, 1, 8'h88);
    step();
    chk("rg.tie_a", {31'd0, ga3}, 32'd1);
    chk("rg.tie_b", {31'd0, gb3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
